// File: rtl/matriz_pkg.sv
// rtl/matriz_pkg.sv - shared LED matrix widths, pattern/index types and column decode
package matriz_pkg;

  localparam int ROW_W = 7;
  localparam int N_COL = 5;
  localparam logic [ROW_W-1:0] LEDS_OFF = 7'b1111111;

  typedef logic [ROW_W-1:0] padrao_t;
  typedef logic [2:0]       indice_t;

  typedef enum logic {S_BLANK, S_ON} estado_t;

  // Index values past the last column shift the bit out, giving all-zero.
  function automatic logic [N_COL-1:0] one_hot(input indice_t i);
    logic [N_COL-1:0] r;
    r = {{(N_COL-1){1'b0}}, 1'b1};
    r = r << i;
    return r;
  endfunction

endpackage

// File: rtl/gerador_tick.sv
// rtl/gerador_tick.sv - free-running 0..DIV_SLOT-1 slot counter with slot-end strobe
module gerador_tick #(
  parameter int DIV_SLOT = 1000,
  parameter int CNT_W    = $clog2(DIV_SLOT)
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic [CNT_W-1:0] cnt,
  output logic             fim
);

  assign fim = (cnt == CNT_W'(DIV_SLOT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (fim) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/varredura_matriz.sv
// rtl/varredura_matriz.sv - 7x5 LED matrix column scanner with blanking and frame snapshot; VARREDURA_BRILHO_EN adds brilho dimming
module varredura_matriz
  import matriz_pkg::*;
#(
  parameter int DIV_SLOT     = 1000,
  parameter int BLANK_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
`ifdef VARREDURA_BRILHO_EN
  input  logic [2:0]       brilho,
`endif
  input  logic [ROW_W-1:0] coluna1,
  input  logic [ROW_W-1:0] coluna2,
  input  logic [ROW_W-1:0] coluna3,
  input  logic [ROW_W-1:0] coluna4,
  input  logic [ROW_W-1:0] coluna5,
  output logic [ROW_W-1:0] linhas,
  output logic [N_COL-1:0] colunas,
  output logic             frame_inicio
);

  localparam int CNT_W = $clog2(DIV_SLOT);

  logic [CNT_W-1:0] cnt;
  logic             fim;
  indice_t          idx;
  estado_t          estado, estado_prox;
  padrao_t          sombra [N_COL];
  padrao_t          padrao_sel;
  logic             recarga;
  logic             habilita;
  logic [ROW_W-1:0] linhas_prox;
  logic [N_COL-1:0] colunas_prox;

  gerador_tick #(
    .DIV_SLOT (DIV_SLOT),
    .CNT_W    (CNT_W)
  ) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .cnt   (cnt),
    .fim   (fim)
  );

  // Leaving cnt=0/idx=0 is both the first edge after reset and the edge
  // whose registered outputs begin the column-1 slot on the pins.
  assign recarga = (cnt == '0) && (idx == '0);

`ifdef VARREDURA_BRILHO_EN
  logic [2:0] brilho_sh;
  logic [2:0] fase;

  assign fase     = 3'({3'b000, cnt} - (CNT_W + 3)'(BLANK_CYCLES));
  assign habilita = (fase <= brilho_sh);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      brilho_sh <= 3'd7;
    end else if (recarga) begin
      brilho_sh <= brilho;
    end
  end
`else
  assign habilita = 1'b1;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx <= '0;
    end else if (fim) begin
      idx <= (idx == indice_t'(N_COL - 1)) ? '0 : idx + indice_t'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < N_COL; k++) begin
        sombra[k] <= LEDS_OFF;
      end
    end else if (recarga) begin
      sombra[0] <= coluna1;
      sombra[1] <= coluna2;
      sombra[2] <= coluna3;
      sombra[3] <= coluna4;
      sombra[4] <= coluna5;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado <= S_BLANK;
    end else begin
      estado <= estado_prox;
    end
  end

  always_comb begin
    padrao_sel = LEDS_OFF;
    case (idx)
      3'd0:    padrao_sel = sombra[0];
      3'd1:    padrao_sel = sombra[1];
      3'd2:    padrao_sel = sombra[2];
      3'd3:    padrao_sel = sombra[3];
      3'd4:    padrao_sel = sombra[4];
      default: padrao_sel = LEDS_OFF;
    endcase
  end

  always_comb begin
    estado_prox  = estado;
    linhas_prox  = LEDS_OFF;
    colunas_prox = '0;
    if (fim) begin
      estado_prox = S_BLANK;
    end else if (cnt == CNT_W'(BLANK_CYCLES - 1)) begin
      estado_prox = S_ON;
    end
    if (estado == S_ON && habilita) begin
      colunas_prox = one_hot(idx);
      linhas_prox  = padrao_sel;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      linhas       <= LEDS_OFF;
      colunas      <= '0;
      frame_inicio <= 1'b0;
    end else begin
      linhas       <= linhas_prox;
      colunas      <= colunas_prox;
      frame_inicio <= recarga;
    end
  end

endmodule

// File: doc/varredura_matriz.md
Name: varredura_matriz

Overview:
- Downstream of the game selector. Consumes the five 7-bit column patterns (coluna1..coluna5) and time-multiplexes them onto a 7-row x 5-column LED matrix.
- Enables one column at a time and drives the rows with that column's pattern.
- Inserts a blanking gap between columns to suppress ghosting.
- Snapshots all five patterns at frame start so a game change never tears a frame.

Parameters:
- DIV_SLOT, 1000: clk cycles per column slot; legal range 4..65535.
- BLANK_CYCLES, 4: cycles at the start of each slot with all columns off; must satisfy 1 <= BLANK_CYCLES < DIV_SLOT.

Ports:
- clk  in  1  system clock; only clock.
- rst_n  in  1  asynchronous active-low reset.
- coluna1..coluna5  in  7 each  column patterns; bit=0 means LED lit (active-low), 7'b1111111 means column dark.
- linhas  out  7  row drive, active-low; bit i = row i of the currently enabled column.
- colunas  out  5  column enable, active-high, one-hot or all-zero; bit 0 = coluna1.
- frame_inicio  out  1  one-cycle pulse when the column-1 slot begins (shadow reload cycle).

Behaviour:
- Reset (async assert, sync deassert handled upstream). All values below apply while rst_n=0:
  - linhas=7'b1111111, colunas=5'b00000, frame_inicio=0.
  - Slot counter cnt=0, column index idx=0.
  - All five shadow registers = 7'b1111111.
- Slot counter: cnt counts 0..DIV_SLOT-1 and wraps.
  - At cnt=DIV_SLOT-1, idx advances 0->1->2->3->4->0 on the next edge.
- FSM per slot, two states:
  - BLANK (cnt < BLANK_CYCLES): colunas=0, linhas=7'h7F.
  - ON (cnt >= BLANK_CYCLES): colunas=one-hot(idx), linhas=shadow[idx].
- Outputs are registered: state/idx/cnt changes appear one clk later on pins, with a uniform 1-cycle latency for every transition.
- Shadow reload:
  - On the edge where idx wraps 4->0, or the first edge after reset release, shadow[k] <= coluna(k+1) for all k simultaneously.
  - frame_inicio=1 for exactly that cycle (registered, coincident with cnt=0, idx=0).
- First frame after reset: shadow loads on the first edge with rst_n=1.
  - Column 1 shows live input data from its first ON cycle; no dark frame beyond the normal blank.
- Input changes mid-frame: ignored until the next frame_inicio.
  - The currently displayed frame stays internally consistent.
- Simultaneous input change and reload edge: the value sampled at that edge is the one loaded.
- Reset mid-slot: outputs go dark immediately (combinational path from rst_n through the async flops only); a new frame starts at column 1 after release.
- colunas is never multi-hot. linhas is always 7'h7F whenever colunas=0.
- Frame period = 5*DIV_SLOT cycles exactly.

Optional Feature:
- Macro: VARREDURA_BRILHO_EN.
- Defined:
  - Extra input port brilho[2:0].
  - Within the ON window, columns are enabled only while (cnt-BLANK_CYCLES) mod 8 <= brilho; otherwise colunas=0 and linhas=7'h7F.
  - brilho=7 is identical to the feature-off behaviour; brilho=0 gives a 1/8 duty.
  - brilho is sampled at frame_inicio alongside the patterns.
- Undefined: no brilho port; full ON window as above.

Decomposition:
- Package matriz_pkg:
  - ROW_W=7, N_COL=5, LEDS_OFF=7'b1111111.
  - Typedef for the 7-bit column pattern and for the 3-bit column index.
- The selector block also uses LEDS_OFF; it shares the package.
- One natural sub-module, gerador_tick: parameterised DIV_SLOT counter producing cnt and a slot-end strobe, reusable by other timed blocks.

Test Plan (DIV_SLOT=8, BLANK_CYCLES=2 unless noted):
- Reset/idle: hold rst_n=0 for 5 clk -> linhas=7'h7F, colunas=0, frame_inicio=0 throughout.
- Basic scan: release reset with coluna1..5 = 7'h3C, 7'h1D, 7'h35, 7'h47, 7'h77.
  - frame_inicio pulses every 40 cycles.
  - Each 8-cycle slot shows 2 cycles colunas=0, then 6 cycles colunas=00001 with linhas=7'h3C, then 00010/7'h1D, and so on through 10000/7'h77.
- Tear-free: change coluna3 from 7'h35 to 7'h3F during the column-2 slot -> the current frame still shows 7'h35 in the column-3 slot; the next frame shows 7'h3F.
- Reset mid-slot: assert rst_n=0 during the column-4 ON window -> colunas=0 and linhas=7'h7F in the same cycle. After release, the first slot is column 1 with a frame_inicio pulse.
- Invariant checker over 10k random-input cycles: $onehot0(colunas) always; colunas==0 implies linhas==7'h7F.
- With VARREDURA_BRILHO_EN, DIV_SLOT=18, brilho=3: each ON window of 16 cycles contains exactly 8 enabled cycles (4 on / 4 off, repeated twice).
